// File: rtl/ramio_memcpy.sv
// ramio_memcpy: word-copy engine driving the cpu-side port of RAMIO.
// Copies word_count 32-bit words from src_addr to dst_addr in forward order,
// one read followed by one write per word, with a per-operation timeout.
module ramio_memcpy #(
    parameter int ADDR_BITWIDTH  = 32,
    parameter int COUNT_BITWIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_BITWIDTH-1:0]  src_addr,
    input  logic [ADDR_BITWIDTH-1:0]  dst_addr,
    input  logic [COUNT_BITWIDTH-1:0] word_count,
    output logic                      active,
    output logic                      done,
    output logic [1:0]                error,
    output logic [COUNT_BITWIDTH-1:0] words_done,
    output logic                      ramio_enable,
    output logic [2:0]                ramio_read_type,
    output logic [1:0]                ramio_write_type,
    output logic [ADDR_BITWIDTH-1:0]  ramio_address,
    output logic [31:0]               ramio_data_in,
    input  logic [31:0]               ramio_data_out,
    input  logic                      ramio_data_out_ready,
    input  logic                      ramio_busy
);

    // Timer holds 0..TIMEOUT_CYCLES-1 wait cycles.
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_MISALIGN  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_FIN
    } state_t;

    state_t                    state_reg, state_next;
    logic [ADDR_BITWIDTH-1:0]  src_reg, src_next;
    logic [ADDR_BITWIDTH-1:0]  dst_reg, dst_next;
    logic [COUNT_BITWIDTH-1:0] remaining_reg, remaining_next;
    logic [COUNT_BITWIDTH-1:0] words_done_reg, words_done_next;
    logic [31:0]               data_reg, data_next;
    logic [TIMER_W-1:0]        timer_reg, timer_next;
    logic [1:0]                error_reg, error_next;

    // Request strobes for the current cycle; enable is their OR.
    logic rd_en;
    logic wr_en;
    logic timeout_hit;

    assign timeout_hit = (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));

    // State and datapath registers; reset aborts any copy without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            remaining_reg  <= '0;
            words_done_reg <= '0;
            data_reg       <= '0;
            timer_reg      <= '0;
            error_reg      <= ERR_OK;
        end else begin
            state_reg      <= state_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            remaining_reg  <= remaining_next;
            words_done_reg <= words_done_next;
            data_reg       <= data_next;
            timer_reg      <= timer_next;
            error_reg      <= error_next;
        end
    end

    // Next-state logic and RAMIO request strobes. Enable drops in the cycle an
    // operation completes, which guarantees an idle cycle between operations.
    always_comb begin
        state_next      = state_reg;
        src_next        = src_reg;
        dst_next        = dst_reg;
        remaining_next  = remaining_reg;
        words_done_next = words_done_reg;
        data_next       = data_reg;
        timer_next      = '0;
        error_next      = error_reg;
        rd_en           = 1'b0;
        wr_en           = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    src_next        = src_addr;
                    dst_next        = dst_addr;
                    remaining_next  = word_count;
                    words_done_next = '0;
                    error_next      = ERR_OK;
                    if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
                        error_next = ERR_MISALIGN;
                        state_next = S_FIN;
                    end else if (word_count == '0) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = S_RD_REQ;
                    end
                end
            end

            S_RD_REQ: begin
                rd_en      = 1'b1;
                state_next = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                if (ramio_data_out_ready) begin
                    data_next  = ramio_data_out;
                    state_next = S_WR_REQ;
                end else if (timeout_hit) begin
                    error_next = ERR_TIMEOUT;
                    state_next = S_FIN;
                end else begin
                    rd_en      = 1'b1;
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end

            S_WR_REQ: begin
                wr_en      = 1'b1;
                state_next = S_WR_WAIT;
            end

            S_WR_WAIT: begin
                if (!ramio_busy) begin
                    words_done_next = words_done_reg + COUNT_BITWIDTH'(1);
                    src_next        = src_reg + ADDR_BITWIDTH'(4);
                    dst_next        = dst_reg + ADDR_BITWIDTH'(4);
                    remaining_next  = remaining_reg - COUNT_BITWIDTH'(1);
                    if (remaining_reg == COUNT_BITWIDTH'(1)) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = S_RD_REQ;
                    end
                end else if (timeout_hit) begin
                    error_next = ERR_TIMEOUT;
                    state_next = S_FIN;
                end else begin
                    wr_en      = 1'b1;
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end

            S_FIN: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // RAMIO port: everything is zero whenever no request is being presented.
    always_comb begin
        ramio_enable     = rd_en | wr_en;
        ramio_read_type  = rd_en ? 3'b111 : 3'b000;
        ramio_write_type = wr_en ? 2'b11  : 2'b00;
        ramio_address    = rd_en ? src_reg : (wr_en ? dst_reg : '0);
        ramio_data_in    = wr_en ? data_reg : 32'd0;
    end

    // Status outputs.
    always_comb begin
        active     = (state_reg == S_RD_REQ) || (state_reg == S_RD_WAIT) ||
                     (state_reg == S_WR_REQ) || (state_reg == S_WR_WAIT);
        done       = (state_reg == S_FIN);
        error      = error_reg;
        words_done = words_done_reg;
    end

endmodule

// File: tb/tb_ramio_memcpy.sv
// Testbench for ramio_memcpy with a small RAMIO stub (2-cycle latency,
// optional read stall) and a table of directed copy vectors.
module tb_ramio_memcpy;

    localparam int TMO   = 16;
    localparam int BOUND = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        active, done;
    logic [1:0]  error;
    logic [15:0] words_done;
    logic        ramio_enable;
    logic [2:0]  ramio_read_type;
    logic [1:0]  ramio_write_type;
    logic [31:0] ramio_address, ramio_data_in;
    logic [31:0] ramio_data_out;
    logic        ramio_data_out_ready;
    logic        ramio_busy;

    always #5 clk = ~clk;

    ramio_memcpy #(
        .ADDR_BITWIDTH (32),
        .COUNT_BITWIDTH(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .src_addr            (src_addr),
        .dst_addr            (dst_addr),
        .word_count          (word_count),
        .active              (active),
        .done                (done),
        .error               (error),
        .words_done          (words_done),
        .ramio_enable        (ramio_enable),
        .ramio_read_type     (ramio_read_type),
        .ramio_write_type    (ramio_write_type),
        .ramio_address       (ramio_address),
        .ramio_data_in       (ramio_data_in),
        .ramio_data_out      (ramio_data_out),
        .ramio_data_out_ready(ramio_data_out_ready),
        .ramio_busy          (ramio_busy)
    );

    // ---------------- RAMIO stub ----------------
    logic [31:0] mem [64];
    logic [31:0] snap [64];
    logic        stall = 1'b0;
    int          rd_cnt, wr_cnt;
    logic [5:0]  rd_idx;
    logic        en_prev, prev_wr;
    int          gap_viol, en_cycles;
    logic        op_wr   [$];
    logic [31:0] op_addr [$];
    logic [31:0] op_data [$];

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt               <= 0;
            wr_cnt               <= 0;
            ramio_busy           <= 1'b0;
            ramio_data_out_ready <= 1'b0;
            ramio_data_out       <= '0;
            en_prev              <= 1'b0;
            prev_wr              <= 1'b0;
        end else begin
            ramio_data_out_ready <= 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
                if (rd_cnt == 1) begin
                    ramio_data_out_ready <= 1'b1;
                    ramio_data_out       <= mem[rd_idx];
                    ramio_busy           <= 1'b0;
                end
            end
            if (wr_cnt > 0) begin
                wr_cnt <= wr_cnt - 1;
                if (wr_cnt == 1) ramio_busy <= 1'b0;
            end
            if (ramio_enable) en_cycles <= en_cycles + 1;
            if (en_prev && ramio_enable && (prev_wr != (ramio_write_type == 2'b11)))
                gap_viol <= gap_viol + 1;
            if (ramio_enable && !en_prev) begin
                op_wr.push_back(ramio_write_type == 2'b11);
                op_addr.push_back(ramio_address);
                op_data.push_back(ramio_data_in);
                if (ramio_write_type == 2'b11) begin
                    mem[ramio_address[7:2]] <= ramio_data_in;
                    wr_cnt     <= 2;
                    ramio_busy <= 1'b1;
                end else if (ramio_read_type == 3'b111 && !stall) begin
                    rd_idx     <= ramio_address[7:2];
                    rd_cnt     <= 2;
                    ramio_busy <= 1'b1;
                end
            end
            en_prev <= ramio_enable;
            prev_wr <= (ramio_write_type == 2'b11);
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] cnt;
        logic [1:0]  err;
        logic [15:0] words;
        int          cyc;
        int          ops;
        logic        act1;
    } vec_t;

    vec_t vecs [7];

    task automatic clear_logs();
        op_wr.delete();
        op_addr.delete();
        op_data.delete();
        gap_viol  = 0;
        en_cycles = 0;
        for (int i = 0; i < 64; i++) snap[i] = mem[i];
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; word_count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns the cycle (1 = first after start was sampled) in which done is
    // seen, or -1 if the bound expires. Pulses a bogus start in cycle 'inject'.
    task automatic wait_done(input int inject, output int cyc, output logic act1);
        logic got;
        got  = 1'b0;
        cyc  = 1;
        act1 = 1'b0;
        while (cyc <= BOUND) begin
            @(negedge clk);
            if (cyc == 1) act1 = active;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc == inject) begin
                src_addr = 32'd2; word_count = 16'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!got) cyc = -1;
    endtask

    task automatic check_ops(input string tag, input logic [31:0] s, input logic [31:0] d, input int n_ops);
        int n;
        n = (op_wr.size() < n_ops) ? op_wr.size() : n_ops;
        check({tag, "_ops"}, op_wr.size(), n_ops);
        for (int i = 0; i < n; i++) begin
            logic [31:0] exp_a;
            exp_a = (i % 2 == 1) ? d + 32'(4 * (i / 2)) : s + 32'(4 * (i / 2));
            check({tag, "_op_kind"}, op_wr[i], (i % 2 == 1));
            check({tag, "_op_addr"}, op_addr[i], exp_a);
            if (i % 2 == 1) begin
                logic [5:0] si;
                si = 6'(s[7:2] + 6'(i / 2));
                check({tag, "_op_data"}, op_data[i], snap[si]);
            end
        end
        check({tag, "_gap"}, gap_viol, 0);
    endtask

    int          cyc;
    logic        act1;
    string       tag;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0011;
        mem[4] = 32'hD5B8A9C4;
        gap_viol = 0;
        en_cycles = 0;

        //           src           dst      cnt err words cyc ops act1
        vecs[0] = '{32'd16,       32'd32,  16'd1, 2'd0, 16'd1, 9,  2, 1'b1};
        vecs[1] = '{32'd0,        32'd64,  16'd4, 2'd0, 16'd4, 33, 8, 1'b1};
        vecs[2] = '{32'd2,        32'd64,  16'd3, 2'd1, 16'd0, 1,  0, 1'b0};
        vecs[3] = '{32'd0,        32'd64,  16'd0, 2'd0, 16'd0, 1,  0, 1'b0};
        vecs[4] = '{32'hFFFFFFFC, 32'd128, 16'd2, 2'd0, 16'd2, 17, 4, 1'b1};
        vecs[5] = '{32'd8,        32'd130, 16'd1, 2'd1, 16'd0, 1,  0, 1'b0};
        vecs[6] = '{32'd100,      32'd200, 16'd3, 2'd0, 16'd3, 25, 6, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {active, done, error, words_done, ramio_enable, ramio_read_type,
               ramio_write_type, ramio_address, ramio_data_in}, 64'd0);
        rst_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            tag = $sformatf("v%0d", v);
            clear_logs();
            launch(vecs[v].src, vecs[v].dst, vecs[v].cnt);
            wait_done(-1, cyc, act1);
            check({tag, "_done_cycle"}, cyc, vecs[v].cyc);
            check({tag, "_active1"}, act1, vecs[v].act1);
            check({tag, "_error"}, error, vecs[v].err);
            check({tag, "_words"}, words_done, vecs[v].words);
            check({tag, "_active_fin"}, active, 0);
            check_ops(tag, vecs[v].src, vecs[v].dst, vecs[v].ops);
            for (int i = 0; i < int'(vecs[v].words); i++) begin
                logic [5:0] si, di;
                si = 6'(vecs[v].src[7:2] + 6'(i));
                di = 6'(vecs[v].dst[7:2] + 6'(i));
                check({tag, "_dst_data"}, mem[di], snap[si]);
            end
            $display("vector %0d src=%0h dst=%0h cnt=%0d -> done@%0d err=%0d words=%0d ops=%0d",
                     v, vecs[v].src, vecs[v].dst, vecs[v].cnt, cyc, error, words_done, op_wr.size());
            // done is a single pulse and error persists into idle
            repeat (2) @(negedge clk);
            check({tag, "_done_pulse"}, done, 0);
            check({tag, "_error_held"}, error, vecs[v].err);
        end

        check("t1_word_at_32", mem[8], 32'hD5B8A9C4);

        // Timeout: stub never answers reads
        stall = 1'b1;
        clear_logs();
        launch(32'd0, 32'd64, 16'd1);
        wait_done(-1, cyc, act1);
        check("tmo_done_cycle", cyc, 18);
        check("tmo_error", error, 2);
        check("tmo_words", words_done, 0);
        check("tmo_enable_cycles", en_cycles, 16);
        check("tmo_ops", op_wr.size(), 1);
        repeat (3) @(negedge clk);
        check("tmo_enable_after", ramio_enable, 0);
        $display("timeout copy -> done@%0d err=%0d enable_cycles=%0d", cyc, error, en_cycles);
        stall = 1'b0;

        // Reset during second word of a 4-word copy
        clear_logs();
        launch(32'd0, 32'd160, 16'd4);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("rst_mid_active", active, 1);
        check("rst_mid_words", words_done, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {active, done, error, words_done, ramio_enable, ramio_read_type,
               ramio_write_type, ramio_address, ramio_data_in}, 64'd0);
        repeat (2) @(negedge clk);
        check("rst_hold_done", done, 0);
        rst_n = 1'b1;
        $display("reset mid-copy -> outputs cleared");

        // Fresh copy after reset, with a bogus start while active
        clear_logs();
        launch(32'd4, 32'd192, 16'd2);
        wait_done(3, cyc, act1);
        check("post_rst_done_cycle", cyc, 17);
        check("post_rst_error", error, 0);
        check("post_rst_words", words_done, 2);
        check_ops("post_rst", 32'd4, 32'd192, 4);
        check("post_rst_dst0", mem[48], snap[1]);
        check("post_rst_dst1", mem[49], snap[2]);
        $display("copy after reset with ignored start -> done@%0d err=%0d words=%0d", cyc, error, words_done);
        repeat (3) @(negedge clk);
        check("post_rst_idle", active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
